// File: rtl/ym_lfo_pkg.sv
// ym_lfo_pkg: shared constants and types for the YM-style LFO generator
package ym_lfo_pkg;

   typedef enum logic [1:0] {
      WAVE_TRI   = 2'd0,
      WAVE_SAW   = 2'd1,
      WAVE_SQR   = 2'd2,
      WAVE_NOISE = 2'd3
   } wave_e;

   localparam int SUB_W = 7;

   localparam logic [SUB_W-1:0] RATE_DIV [8] = '{
      7'd108, 7'd77, 7'd71, 7'd67, 7'd62, 7'd44, 7'd8, 7'd5
   };

   localparam logic [7:0] PM_COEF [8][8] = '{
      '{8'd0, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0},
      '{8'd0, 8'd0, 8'd0, 8'd0,  8'd1,  8'd1,  8'd1,  8'd1},
      '{8'd0, 8'd0, 8'd0, 8'd1,  8'd1,  8'd1,  8'd2,  8'd2},
      '{8'd0, 8'd0, 8'd1, 8'd1,  8'd2,  8'd2,  8'd3,  8'd3},
      '{8'd0, 8'd0, 8'd1, 8'd2,  8'd2,  8'd3,  8'd3,  8'd4},
      '{8'd0, 8'd0, 8'd2, 8'd3,  8'd4,  8'd4,  8'd5,  8'd6},
      '{8'd0, 8'd0, 8'd4, 8'd6,  8'd8,  8'd8,  8'd10, 8'd12},
      '{8'd0, 8'd0, 8'd8, 8'd12, 8'd16, 8'd16, 8'd20, 8'd24}
   };

   localparam logic [16:0] LFSR_SEED = 17'd1;

endpackage

// File: rtl/ym_lfo_pm.sv
// ym_lfo_pm: two-stage PM pipeline, multiply in stage 1, signed add in stage 2
module ym_lfo_pm
   import ym_lfo_pkg::*;
#(
   parameter int FNUM_WIDTH = 11
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [FNUM_WIDTH-1:0] fnum_i,
   input  logic [2:0]            pms_i,
   input  logic [2:0]            step_i,
   input  logic                  sign_i,
   output logic                  valid_o,
   output logic [FNUM_WIDTH:0]   fnum_o
);
   localparam int OW = FNUM_WIDTH + 1;

   logic          v1_q, v2_q, sign_q;
   logic [OW-1:0] base_q, base_d, off_q, off_d, out_q, out_d;
   logic [14:0]   prod;

   // stage 1 scales the top F-number bits by the coefficient; stage 2 applies it and holds between results
   always_comb begin
      prod   = 15'(fnum_i[FNUM_WIDTH-1 -: 7]) * 15'(PM_COEF[pms_i][step_i]);
      base_d = {fnum_i, 1'b0};
      off_d  = OW'(prod >> 3);
      out_d  = v1_q ? (sign_q ? base_q - off_q : base_q + off_q) : out_q;
   end

   // pipeline registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         sign_q <= 1'b0;
         base_q <= '0;
         off_q  <= '0;
         out_q  <= '0;
      end else begin
         v1_q   <= valid_i;
         v2_q   <= v1_q;
         sign_q <= sign_i;
         base_q <= base_d;
         off_q  <= off_d;
         out_q  <= out_d;
      end
   end

   assign valid_o = v2_q;
   assign fnum_o  = out_q;

endmodule

// File: rtl/ym_lfo_gen.sv
// ym_lfo_gen: frame-locked LFO producing AM attenuation and PM-modulated F-numbers; noise wave enabled by YM_LFO_NOISE_EN
module ym_lfo_gen
   import ym_lfo_pkg::*;
#(
   parameter int SLOTS      = 24,
   parameter int CNT_WIDTH  = 7,
   parameter int FNUM_WIDTH = 11
) (
   input  logic                  MCLK,
   input  logic                  reset,
   input  logic                  slot_ce,
   input  logic                  lfo_en,
   input  logic [2:0]            rate,
   input  logic [1:0]            wave,
   input  logic                  sync,
   input  logic                  fnum_valid,
   input  logic [FNUM_WIDTH-1:0] fnum,
   input  logic [2:0]            pms,
   output logic                  frame_tick,
   output logic [CNT_WIDTH-2:0]  lfo_am,
   output logic                  fnum_lfo_valid,
   output logic [FNUM_WIDTH:0]   fnum_lfo
);
   localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
   localparam int AW = CNT_WIDTH - 1;

   logic [SW-1:0]        slot_q, slot_d;
   logic [SUB_W-1:0]     sub_q, sub_d;
   logic [CNT_WIDTH-1:0] phase_q, phase_d;
   logic [AW-1:0]        am_q, am_d, am_tri, am_noise, am_shape;
   logic [2:0]           pm_raw, pm_step_q, pm_step_d;
   logic                 pm_sign_q, pm_sign_d, step;

   if (CNT_WIDTH > 4) begin : g_step
      assign pm_raw = phase_q[CNT_WIDTH-3 -: 3];
   end else begin : g_step
      assign pm_raw = {phase_q[1:0], 1'b0};
   end

   assign frame_tick = slot_ce && slot_q == SW'(SLOTS - 1);
   assign step       = frame_tick && lfo_en && sub_q == RATE_DIV[rate] - 7'd1;
   assign am_tri     = phase_q[CNT_WIDTH-1] ? phase_q[AW-1:0] : ~phase_q[AW-1:0];

`ifdef YM_LFO_NOISE_EN
   logic [16:0] lfsr_q, lfsr_d;

   // noise source advances once per LFO step
   always_comb lfsr_d = step ? {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]} : lfsr_q;

   // noise register, reseeded on reset
   always_ff @(posedge MCLK) lfsr_q <= reset ? LFSR_SEED : lfsr_d;

   assign am_noise = lfsr_q[AW-1:0];
`else
   assign am_noise = am_tri;
`endif

   // counter next-states; equality compare lets a sub-counter past a lowered threshold wrap without stepping
   always_comb begin
      slot_d    = !slot_ce ? slot_q : frame_tick ? '0 : slot_q + SW'(1);
      sub_d     = (!lfo_en || sync || step) ? '0 : frame_tick ? sub_q + 7'd1 : sub_q;
      phase_d   = (!lfo_en || sync) ? '0 : step ? phase_q + CNT_WIDTH'(1) : phase_q;
      am_shape  = wave == WAVE_SAW ? phase_q[AW-1:0] :
                  wave == WAVE_SQR ? {AW{~phase_q[CNT_WIDTH-1]}} :
                  wave == WAVE_NOISE ? am_noise : am_tri;
      am_d      = frame_tick ? am_shape : am_q;
      pm_step_d = frame_tick ? pm_raw ^ {3{phase_q[CNT_WIDTH-2]}} : pm_step_q;
      pm_sign_d = frame_tick ? phase_q[CNT_WIDTH-1] : pm_sign_q;
   end

   // counters and the per-frame lock register
   always_ff @(posedge MCLK) begin
      if (reset) begin
         slot_q    <= '0;
         sub_q     <= '0;
         phase_q   <= '0;
         am_q      <= '0;
         pm_step_q <= '0;
         pm_sign_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         sub_q     <= sub_d;
         phase_q   <= phase_d;
         am_q      <= am_d;
         pm_step_q <= pm_step_d;
         pm_sign_q <= pm_sign_d;
      end
   end

   assign lfo_am = am_q;

   ym_lfo_pm #(
      .FNUM_WIDTH(FNUM_WIDTH)
   ) u_pm (
      .clk_i   (MCLK),
      .rst_i   (reset),
      .valid_i (fnum_valid),
      .fnum_i  (fnum),
      .pms_i   (pms),
      .step_i  (pm_step_q),
      .sign_i  (pm_sign_q),
      .valid_o (fnum_lfo_valid),
      .fnum_o  (fnum_lfo)
   );

endmodule

// File: tb/tb_ym_lfo_gen.sv
// tb_ym_lfo_gen: directed vector bench for ym_lfo_gen (default parameters)
module tb_ym_lfo_gen;
   logic        MCLK = 1'b0, reset = 1'b1, slot_ce = 1'b1, lfo_en = 1'b0, sync = 1'b0, fnum_valid = 1'b0;
   logic [2:0]  rate = 3'd7, pms = 3'd0;
   logic [1:0]  wave = 2'd0;
   logic [10:0] fnum = '0;
   logic        frame_tick, fnum_lfo_valid;
   logic [5:0]  lfo_am;
   logic [11:0] fnum_lfo;
   int nvec = 0, nfail = 0, k = 0;

`ifdef YM_LFO_NOISE_EN
   localparam bit NOISE = 1'b1;
`else
   localparam bit NOISE = 1'b0;
`endif

   typedef struct {
      int         ph;
      logic [1:0] wv;
      logic [2:0] ps;
      logic [10:0] fn;
      int         am;
      int         fo;
   } vec_t;
   vec_t tbl [17];

   always #5 MCLK = ~MCLK;

   ym_lfo_gen dut (
      .MCLK           (MCLK),
      .reset          (reset),
      .slot_ce        (slot_ce),
      .lfo_en         (lfo_en),
      .rate           (rate),
      .wave           (wave),
      .sync           (sync),
      .fnum_valid     (fnum_valid),
      .fnum           (fnum),
      .pms            (pms),
      .frame_tick     (frame_tick),
      .lfo_am         (lfo_am),
      .fnum_lfo_valid (fnum_lfo_valid),
      .fnum_lfo       (fnum_lfo)
   );

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge MCLK);
      reset = 1'b0;
      k = 0;
   endtask

   task automatic tick(input bit s);
      int n;
      n = 0;
      do begin
         @(negedge MCLK);
         n++;
      end while (!frame_tick && n < 60);
      if (!frame_tick) chk("tick_timeout", 0, 1);
      sync = s;
      @(negedge MCLK);
      sync = 1'b0;
      k++;
   endtask

   task automatic pm_req(input logic [10:0] fn, input logic [2:0] ps, input int exp, input string nm);
      fnum = fn;
      pms = ps;
      fnum_valid = 1'b1;
      @(negedge MCLK);
      fnum_valid = 1'b0;
      chk({nm, "_valid_early"}, fnum_lfo_valid, 0);
      @(negedge MCLK);
      chk({nm, "_valid"}, fnum_lfo_valid, 1);
      chk({nm, "_fnum"}, fnum_lfo, exp);
      @(negedge MCLK);
      chk({nm, "_valid_drop"}, fnum_lfo_valid, 0);
      chk({nm, "_hold"}, fnum_lfo, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t;
      bit seen;
      tbl[0]  = '{0,   2'd0, 3'd0, 11'h7FF, 63,               'hFFE};
      tbl[1]  = '{0,   2'd1, 3'd7, 11'h400, 0,                'h800};
      tbl[2]  = '{0,   2'd2, 3'd3, 11'h123, 63,               'h246};
      tbl[3]  = '{0,   2'd3, 3'd0, 11'h055, NOISE ? 1 : 63,   'h0AA};
      tbl[4]  = '{2,   2'd3, 3'd0, 11'h3FF, NOISE ? 4 : 61,   'h7FE};
      tbl[5]  = '{10,  2'd0, 3'd7, 11'h7FF, 53,               'h07D};
      tbl[6]  = '{10,  2'd1, 3'd6, 11'h400, 10,               'h820};
      tbl[7]  = '{10,  2'd2, 3'd5, 11'h2A5, 63,               'h554};
      tbl[8]  = '{10,  2'd3, 3'd1, 11'h001, NOISE ? 0 : 53,   'h002};
      tbl[9]  = '{17,  2'd3, 3'd6, 11'h080, NOISE ? 9 : 46,   'h108};
      tbl[10] = '{45,  2'd0, 3'd4, 11'h7F0, 18,               'hFFF};
      tbl[11] = '{45,  2'd1, 3'd2, 11'h0F0, 45,               'h1E1};
      tbl[12] = '{64,  2'd0, 3'd7, 11'h7FF, 0,                'hFFE};
      tbl[13] = '{64,  2'd2, 3'd0, 11'h100, 0,                'h200};
      tbl[14] = '{90,  2'd0, 3'd7, 11'h7FF, 26,               'hEC1};
      tbl[15] = '{90,  2'd1, 3'd3, 11'h050, 26,               'h09F};
      tbl[16] = '{127, 2'd2, 3'd7, 11'h7FF, 0,                'hFFE};

      // reset state, with a request held high during reset
      lfo_en = 1'b1;
      wave = 2'd1;
      fnum = 11'h7FF;
      fnum_valid = 1'b1;
      repeat (3) @(negedge MCLK);
      chk("rst_am", lfo_am, 0);
      chk("rst_tick", frame_tick, 0);
      chk("rst_valid", fnum_lfo_valid, 0);
      chk("rst_fnum", fnum_lfo, 0);
      fnum_valid = 1'b0;
      reset = 1'b0;
      n = 0;
      do begin @(negedge MCLK); n++; end while (!frame_tick && n < 60);
      chk("first_tick_cycles", n, 23);
      @(negedge MCLK);
      chk("tick_one_cycle", frame_tick, 0);
      n = 1;
      do begin @(negedge MCLK); n++; end while (!frame_tick && n < 60);
      chk("frame_period", n, 24);

      // rate lowered while the sub-counter is already past the new threshold
      rate = 3'd6;
      do_reset();
      repeat (6) tick(1'b0);
      rate = 3'd7;
      repeat (6) tick(1'b0);
      chk("rate_no_spurious", lfo_am, 0);

      // sync on the step cycle, then lfo_en low
      do_reset();
      repeat (4) tick(1'b0);
      tick(1'b1);
      tick(1'b0);
      chk("sync_step", lfo_am, 0);
      repeat (5) tick(1'b0);
      chk("sync_resume", lfo_am, 1);
      lfo_en = 1'b0;
      tick(1'b0);
      chk("en_off_clear", lfo_am, 0);
      lfo_en = 1'b1;

      // table: walk the phase forward, checking AM and a PM request at each stop
      do_reset();
      for (int i = 0; i < 17; i++) begin
         wave = tbl[i].wv;
         t = (k + 1 > 5 * tbl[i].ph + 1) ? k + 1 : 5 * tbl[i].ph + 1;
         while (k < t) tick(1'b0);
         chk($sformatf("v%0d_am", i), lfo_am, tbl[i].am);
         pm_req(tbl[i].fn, tbl[i].ps, tbl[i].fo, $sformatf("v%0d", i));
      end

      // phase wrap 127 -> 0
      wave = 2'd1;
      while (k < 640) tick(1'b0);
      chk("wrap_127", lfo_am, 63);
      tick(1'b0);
      chk("wrap_0", lfo_am, 0);

      // reset with a request in flight
      wave = 2'd0;
      tick(1'b0);
      chk("tri_after_wrap", lfo_am, 63);
      pm_req(11'h7FF, 3'd0, 'hFFE, "pre_rst");
      fnum = 11'h123;
      fnum_valid = 1'b1;
      @(negedge MCLK);
      fnum_valid = 1'b0;
      reset = 1'b1;
      @(negedge MCLK);
      chk("mid_rst_am", lfo_am, 0);
      chk("mid_rst_tick", frame_tick, 0);
      chk("mid_rst_valid", fnum_lfo_valid, 0);
      chk("mid_rst_fnum", fnum_lfo, 0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge MCLK);
         if (fnum_lfo_valid) seen = 1'b1;
      end
      chk("rst_no_valid", seen, 0);

      // back-to-back requests
      pms = 3'd0;
      fnum_valid = 1'b1;
      fnum = 11'd1;
      @(negedge MCLK);
      fnum = 11'd2;
      chk("b2b_v0", fnum_lfo_valid, 0);
      @(negedge MCLK);
      fnum = 11'd3;
      chk("b2b_v1", fnum_lfo_valid, 1);
      chk("b2b_f1", fnum_lfo, 2);
      @(negedge MCLK);
      fnum_valid = 1'b0;
      chk("b2b_v2", fnum_lfo_valid, 1);
      chk("b2b_f2", fnum_lfo, 4);
      @(negedge MCLK);
      chk("b2b_v3", fnum_lfo_valid, 1);
      chk("b2b_f3", fnum_lfo, 6);
      @(negedge MCLK);
      chk("b2b_v4", fnum_lfo_valid, 0);
      chk("b2b_hold", fnum_lfo, 6);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
